// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, the $zero index and the grant encodings for the writeback path
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic GNT_REQ0 = 1'b0;
  localparam logic GNT_REQ1 = 1'b1;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: combinational two-way round-robin pick; the requester that did not win last time wins a tie
module rr_arbiter_2
  import regfile_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt_onehot,
  output logic       gnt_idx
);
  // a tie goes to the requester other than last; a single request wins outright
  always_comb begin
    gnt_idx    = (valid == 2'b11) ? ~last : (valid[1] ? GNT_REQ1 : GNT_REQ0);
    gnt_onehot = (en && |valid) ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file write port between two writeback requesters (optional forwarding: REGFILE_ARB_FWD_EN)
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_W,
  parameter int ADDR_WIDTH = REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_reg,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_reg,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  hold,
  output logic                  write_en,
  output logic [ADDR_WIDTH-1:0] write_reg,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  last_grant
`ifdef REGFILE_ARB_FWD_EN
  ,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [DATA_WIDTH-1:0] fwd_data
`endif
);
  logic [1:0]            gnt;
  logic                  gnt_idx;
  logic                  write_en_q, write_en_d;
  logic [ADDR_WIDTH-1:0] write_reg_q, write_reg_d, sel_reg;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d, sel_data;
  logic                  last_grant_q, last_grant_d;

  rr_arbiter_2 u_rr (
    .valid      ({req1_valid, req0_valid}),
    .last       (last_grant_q),
    .en         (!hold && !rst),
    .gnt_onehot (gnt),
    .gnt_idx    (gnt_idx)
  );

  // pick the winner's payload; a $zero destination is acknowledged but never written
  always_comb begin
    sel_reg      = gnt_idx ? req1_reg : req0_reg;
    sel_data     = gnt_idx ? req1_data : req0_data;
    write_en_d   = |gnt && sel_reg != ADDR_WIDTH'(REG_ZERO);
    write_reg_d  = write_en_d ? sel_reg : write_reg_q;
    write_data_d = write_en_d ? sel_data : write_data_q;
    last_grant_d = |gnt ? gnt_idx : last_grant_q;
  end

  // output register and round-robin history; reset drops any in-flight write
  always_ff @(posedge clk) begin
    if (rst) begin
      write_en_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      last_grant_q <= GNT_REQ1;
    end else begin
      write_en_q   <= write_en_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign write_en   = write_en_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign last_grant = last_grant_q;

`ifdef REGFILE_ARB_FWD_EN
  // bypass the write being committed this cycle to readers of the same register
  always_comb begin
    fwd_hit1 = write_en_q && write_reg_q == read_reg1 && read_reg1 != ADDR_WIDTH'(REG_ZERO);
    fwd_hit2 = write_en_q && write_reg_q == read_reg2 && read_reg2 != ADDR_WIDTH'(REG_ZERO);
    fwd_data = write_data_q;
  end
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: scoreboard bench for the writeback port arbiter
module tb_regfile_write_arbiter;
  import regfile_pkg::*;
  localparam int AW = 5;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst, hold;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [AW-1:0] req0_reg, req1_reg, write_reg;
  logic [DW-1:0] req0_data, req1_data, write_data;
  logic write_en, last_grant;
`ifdef REGFILE_ARB_FWD_EN
  logic [AW-1:0] read_reg1, read_reg2;
  logic fwd_hit1, fwd_hit2;
  logic [DW-1:0] fwd_data;
`endif
  typedef struct {logic [AW-1:0] r; logic [DW-1:0] d;} wr_t;
  wr_t sb[$];
  int total = 0;
  int bad = 0;
  logic m_last, m_we, acc0, acc1;
  logic [AW-1:0] m_reg;
  logic [DW-1:0] m_data;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
    .hold(hold), .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
    .last_grant(last_grant)
`ifdef REGFILE_ARB_FWD_EN
    , .read_reg1(read_reg1), .read_reg2(read_reg2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data(fwd_data)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // one clock: predict grants from the current inputs, check readies, then check the registered outputs
  task automatic tick();
    logic g0, g1;
    wr_t w;
    #1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst && !hold) begin
      if (req0_valid && req1_valid) begin
        g0 = m_last;
        g1 = !m_last;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
    end
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    m_we = 1'b0;
    if (g0 || g1) begin
      m_last = g1;
      w.r = g1 ? req1_reg : req0_reg;
      w.d = g1 ? req1_data : req0_data;
      if (w.r != 0) begin
        sb.push_back(w);
        m_we = 1'b1;
      end
    end
    if (rst) begin
      m_last = 1'b1;
      m_reg = '0;
      m_data = '0;
      sb.delete();
    end
    acc0 = g0;
    acc1 = g1;
    @(posedge clk);
    #1;
    chk("write_en", write_en, m_we);
    if (m_we && sb.size() > 0) begin
      w = sb.pop_front();
      m_reg = w.r;
      m_data = w.d;
    end
    chk("write_reg", write_reg, m_reg);
    chk("write_data", write_data, m_data);
    chk("last_grant", last_grant, m_last);
    @(negedge clk);
  endtask

  task automatic drive(input logic v0, input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] r1, input logic [DW-1:0] d1);
    req0_valid = v0; req0_reg = r0; req0_data = d0;
    req1_valid = v1; req1_reg = r1; req1_data = d1;
  endtask

  initial begin
    m_last = 1'b1; m_we = 1'b0; m_reg = '0; m_data = '0;
    rst = 1'b1; hold = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
`ifdef REGFILE_ARB_FWD_EN
    read_reg1 = '0; read_reg2 = '0;
`endif
    @(negedge clk);
    tick();
    drive(1'b1, 5'd9, 32'd1, 1'b1, 5'd8, 32'd2);
    tick();
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    chk("reset_we", write_en, 1'b0);
    chk("reset_last", last_grant, 1'b1);
    drive(1'b1, 5'd1, 32'd7200, 1'b0, '0, '0);
    tick();
    chk("t1_reg", write_reg, 5'd1);
    chk("t1_data", write_data, 32'd7200);
    drive(1'b1, 5'd2, 32'd3600, 1'b1, 5'd3, 32'd1800);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_data", write_data, (i % 2 == 0) ? 32'd1800 : 32'd3600);
    end
    drive(1'b1, 5'd5, 32'd11, 1'b0, '0, '0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 5'd0, 32'd9000);
    tick();
    chk("t3_we", write_en, 1'b0);
    chk("t3_last", last_grant, 1'b1);
    chk("t3_data", write_data, 32'd11);
    hold = 1'b1;
    drive(1'b1, 5'd6, 32'd66, 1'b1, 5'd7, 32'd77);
    for (int i = 0; i < 3; i++) tick();
    hold = 1'b0;
    tick();
    chk("t4_first", write_data, 32'd66);
    drive(1'b1, 5'd4, 32'd5400, 1'b0, '0, '0);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    rst = 1'b1;
    tick();
    chk("t5_we", write_en, 1'b0);
    chk("t5_last", last_grant, 1'b1);
    rst = 1'b0;
    tick();
`ifdef REGFILE_ARB_FWD_EN
    drive(1'b0, '0, '0, 1'b1, 5'd3, 32'd1800);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    read_reg1 = 5'd3; read_reg2 = 5'd0;
    #1;
    chk("fwd_hit1", fwd_hit1, 1'b1);
    chk("fwd_hit2", fwd_hit2, 1'b0);
    chk("fwd_data", fwd_data, 32'd1800);
    read_reg2 = 5'd4;
    #1;
    chk("fwd_miss", fwd_hit2, 1'b0);
    tick();
    chk("fwd_idle", fwd_hit1, 1'b0);
`endif
    acc0 = 1'b1; acc1 = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid || acc0) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_reg = AW'($urandom_range(0, 31));
        req0_data = $urandom;
      end
      if (!req1_valid || acc1) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_reg = AW'($urandom_range(0, 31));
        req1_data = $urandom;
      end
      hold = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 63) == 0);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
